// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared 7-seg display constants
// Shared by the display mux, the scan driver and the counting logic.
package disp_pkg;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BLANK = 4'hF;
endpackage

// File: rtl/tick_div.sv
// rtl/tick_div.sv - clearable tick divider
// Counts 0..DIV-1 while enabled; emits a one-cycle tick at DIV-1 and wraps.
module tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tick = enable && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/page_disp_mux.sv
// rtl/page_disp_mux.sv - multi-page 7-seg display multiplexer
// Page counter, edit-mode blink of the selected field, registered digit output.
module page_disp_mux
    import disp_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int PAGES = 2,
    parameter int BLINK_DIV = 25_000_000,
    parameter int SCROLL_DIV = 0,
    parameter logic [DIGITS-1:0] FIELD0_MASK = 4'b1100,
    parameter logic [DIGITS-1:0] FIELD1_MASK = 4'b0011
) (
    input  logic                               CLK,
    input  logic                               RST_n,
    input  logic                               EN_work,
    input  logic                               EN_set,
    input  logic                               SET,
    input  logic                               page_next,
    input  logic                               auto_scroll,
    input  logic [DIGIT_W-1:0]                 mode_digit,
    input  logic [PAGES*DIGITS*DIGIT_W-1:0]    page_data,
    output logic [(DIGITS+1)*DIGIT_W-1:0]      disp_out,
    output logic [$clog2(PAGES)-1:0]           page_idx,
    output logic                               blink_phase
);
    localparam int PW = $clog2(PAGES);
    localparam logic [PW-1:0] LAST_PAGE = PW'(PAGES - 1);

    logic edit;
    logic edit_q;
    logic edit_rise;
    logic blink_tick;
    logic scroll_tick;
    logic [DIGITS-1:0] mask;
    logic [DIGITS*DIGIT_W-1:0] digits;

    assign edit = EN_set && !EN_work;
    assign edit_rise = edit && !edit_q;
    assign mask = SET ? FIELD1_MASK : FIELD0_MASK;

    // Entering edit restarts the blink so the field always begins visible.
    tick_div #(.DIV(BLINK_DIV)) u_blink_div (
        .clk    (CLK),
        .rst_n  (RST_n),
        .clear  (!edit || edit_rise),
        .enable (edit),
        .tick   (blink_tick)
    );

    generate
        if (SCROLL_DIV > 0) begin : g_scroll
            // A manual page step restarts the scroll interval.
            tick_div #(.DIV(SCROLL_DIV)) u_scroll_div (
                .clk    (CLK),
                .rst_n  (RST_n),
                .clear  (!auto_scroll || edit || page_next),
                .enable (auto_scroll && !edit),
                .tick   (scroll_tick)
            );
        end else begin : g_no_scroll
            assign scroll_tick = 1'b0;
        end
    endgenerate

    always_comb begin
        digits = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (edit && blink_phase && mask[i] && (page_idx == '0)) begin
                digits[i*DIGIT_W +: DIGIT_W] = BLANK;
            end else begin
                digits[i*DIGIT_W +: DIGIT_W] =
                    page_data[(int'(page_idx) * DIGITS + i) * DIGIT_W +: DIGIT_W];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            edit_q      <= 1'b0;
            page_idx    <= '0;
            blink_phase <= 1'b0;
            disp_out    <= {(DIGITS+1){BLANK}};
        end else begin
            edit_q <= edit;

            if (edit) begin
                page_idx <= '0;
            end else if (page_next || scroll_tick) begin
                page_idx <= (page_idx == LAST_PAGE) ? '0 : page_idx + 1'b1;
            end

            if (!edit || edit_rise) begin
                blink_phase <= 1'b0;
            end else if (blink_tick) begin
                blink_phase <= !blink_phase;
            end

            disp_out <= {mode_digit, digits};
        end
    end
endmodule

// File: tb/tb_page_disp_mux.sv
// tb/tb_page_disp_mux.sv - directed self-checking bench for page_disp_mux
module tb_page_disp_mux;
    logic        CLK = 1'b0;
    logic        RST_n;
    logic        EN_work;
    logic        EN_set;
    logic        SET;
    logic        page_next;
    logic        auto_scroll;
    logic [3:0]  mode_digit;
    logic [47:0] page_data;
    logic [19:0] disp_out;
    logic [1:0]  page_idx;
    logic        blink_phase;

    int compared = 0;
    int mismatched = 0;

    page_disp_mux #(
        .DIGITS      (4),
        .PAGES       (3),
        .BLINK_DIV   (4),
        .SCROLL_DIV  (8),
        .FIELD0_MASK (4'b1100),
        .FIELD1_MASK (4'b0011)
    ) dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .EN_work     (EN_work),
        .EN_set      (EN_set),
        .SET         (SET),
        .page_next   (page_next),
        .auto_scroll (auto_scroll),
        .mode_digit  (mode_digit),
        .page_data   (page_data),
        .disp_out    (disp_out),
        .page_idx    (page_idx),
        .blink_phase (blink_phase)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_next();
        page_next = 1'b1;
        @(negedge CLK);
        page_next = 1'b0;
    endtask

    initial begin
        RST_n = 1'b0;
        EN_work = 1'b0;
        EN_set = 1'b0;
        SET = 1'b0;
        page_next = 1'b0;
        auto_scroll = 1'b0;
        mode_digit = 4'hA;
        page_data = {16'h9ABC, 16'h5678, 16'h1234};

        @(negedge CLK);
        chk("reset_disp", disp_out, 20'hFFFFF);
        chk("reset_page", {18'd0, page_idx}, 20'd0);
        chk("reset_blink", {19'd0, blink_phase}, 20'd0);
        RST_n = 1'b1;
        @(negedge CLK);
        chk("page0_disp", disp_out, 20'hA1234);

        // Manual paging with one-cycle output lag and wrap.
        pulse_next();
        chk("next1_page", {18'd0, page_idx}, 20'd1);
        chk("next1_lag", disp_out, 20'hA1234);
        @(negedge CLK);
        chk("next1_disp", disp_out, 20'hA5678);
        pulse_next();
        chk("next2_page", {18'd0, page_idx}, 20'd2);
        @(negedge CLK);
        chk("next2_disp", disp_out, 20'hA9ABC);
        pulse_next();
        chk("next3_wrap", {18'd0, page_idx}, 20'd0);
        @(negedge CLK);
        chk("next3_disp", disp_out, 20'hA1234);

        // Auto scroll every 8 cycles; coincident page_next gives one step.
        auto_scroll = 1'b1;
        repeat (7) @(negedge CLK);
        chk("scroll_hold", {18'd0, page_idx}, 20'd0);
        @(negedge CLK);
        chk("scroll_step1", {18'd0, page_idx}, 20'd1);
        repeat (7) @(negedge CLK);
        chk("scroll_hold2", {18'd0, page_idx}, 20'd1);
        pulse_next();
        chk("coincident_single", {18'd0, page_idx}, 20'd2);
        repeat (7) @(negedge CLK);
        chk("scroll_restart", {18'd0, page_idx}, 20'd2);
        @(negedge CLK);
        chk("scroll_wrap", {18'd0, page_idx}, 20'd0);
        repeat (8) @(negedge CLK);
        chk("scroll_step3", {18'd0, page_idx}, 20'd1);

        // Asynchronous reset in the middle of a cycle.
        #2 RST_n = 1'b0;
        #1;
        chk("async_rst_disp", disp_out, 20'hFFFFF);
        chk("async_rst_page", {18'd0, page_idx}, 20'd0);
        chk("async_rst_blink", {19'd0, blink_phase}, 20'd0);
        auto_scroll = 1'b0;
        RST_n = 1'b1;
        @(negedge CLK);
        chk("post_rst_disp", disp_out, 20'hA1234);

        // Edit entered on page 2.
        pulse_next();
        pulse_next();
        chk("pre_edit_page", {18'd0, page_idx}, 20'd2);
        EN_set = 1'b1;
        @(negedge CLK);
        chk("edit_page0", {18'd0, page_idx}, 20'd0);
        chk("edit_blink0", {19'd0, blink_phase}, 20'd0);
        chk("edit_lag_disp", disp_out, 20'hA9ABC);
        page_next = 1'b1;
        @(negedge CLK);
        page_next = 1'b0;
        chk("edit_next_ignored", {18'd0, page_idx}, 20'd0);
        chk("edit_vis1", disp_out, 20'hA1234);
        repeat (3) @(negedge CLK);
        chk("edit_vis4", disp_out, 20'hA1234);
        chk("edit_phase1", {19'd0, blink_phase}, 20'd1);
        @(negedge CLK);
        chk("edit_blank_f0", disp_out, 20'hAFF34);
        @(negedge CLK);
        chk("edit_blank_f0b", disp_out, 20'hAFF34);
        SET = 1'b1;
        @(negedge CLK);
        chk("edit_blank_f1", disp_out, 20'hA12FF);
        @(negedge CLK);
        chk("edit_blank_f1b", disp_out, 20'hA12FF);
        chk("edit_phase_back0", {19'd0, blink_phase}, 20'd0);
        @(negedge CLK);
        chk("edit_vis_again", disp_out, 20'hA1234);

        // Leaving edit clears the phase and re-enables paging.
        EN_set = 1'b0;
        @(negedge CLK);
        chk("leave_blink", {19'd0, blink_phase}, 20'd0);
        chk("leave_page", {18'd0, page_idx}, 20'd0);
        pulse_next();
        chk("leave_next", {18'd0, page_idx}, 20'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
